traffic_light_rr: RTL and testbench
===================================

TRAFFIC_LIGHT_RR -- requirements
Module: traffic_light_rr

Interface
REQ-001 Parameter N_DIR, default 4, number of approach directions; legal range 2..8.
REQ-002 Parameter CNT_W, default 8, width of the phase timer.
REQ-003 Parameter T_GREEN_MIN, default 4, minimum green length in cycles.
REQ-004 Parameter T_GREEN_MAX, default 10, maximum green length in cycles when other demand is pending.
REQ-005 Parameters T_YELLOW, T_ALLRED and T_WALK, defaults 2, 1 and 3, phase lengths in cycles.
REQ-006 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-007 i_rst  input  1  reset, asynchronous, active-high.
REQ-008 i_sense  input  N_DIR  per-direction vehicle presence, level-sensitive.
REQ-009 i_ped  input  1  pedestrian request, pulse or level.
REQ-010 i_hold  input  1  maintenance hold; freezes the current green.
REQ-011 o_light  output  2*N_DIR  lamp code per direction; bits [2k+1:2k] are direction k; 00 red, 01 yellow, 10 green.
REQ-012 o_walk  output  1  pedestrian walk lamp.
REQ-013 o_dir  output  clog2(N_DIR)  index of the current or last served direction.
REQ-014 o_phase  output  2  current phase: 0 GREEN, 1 YELLOW, 2 ALLRED, 3 WALK.

Function
REQ-015 The FSM SHALL have four phases, GREEN, YELLOW, ALLRED and WALK; the phase timer clears on every phase change and increments by one each cycle otherwise.
REQ-016 A phase of length T SHALL last exactly T cycles; the exit condition is tested when timer == T-1.
REQ-017 Demand in GREEN SHALL be defined as any i_sense bit other than o_dir set, or ped_pend set.
REQ-018 GREEN SHALL exit to YELLOW when all of the following hold: demand is present, timer >= T_GREEN_MIN-1, i_hold=0, and either i_sense[o_dir]=0 or timer == T_GREEN_MAX-1.
REQ-019 With no demand, GREEN SHALL rest indefinitely; the timer saturates at its maximum value and does not wrap.
REQ-020 YELLOW SHALL be followed by ALLRED.
REQ-021 ALLRED SHALL be followed by WALK if ped_pend=1; otherwise ALLRED SHALL be followed by GREEN of the next direction.
REQ-022 WALK SHALL be followed by GREEN of the next direction.
REQ-023 The next direction SHALL be the first index after o_dir, modulo N_DIR, whose i_sense bit is set, searched in ascending wrap order; if no bit is set, it SHALL be (o_dir+1) mod N_DIR.
REQ-024 ped_pend SHALL be set on the edge after i_ped=1 is sampled.
REQ-025 ped_pend SHALL clear on entry to WALK; if i_ped is also asserted on that same entry edge, clear wins.
REQ-026 When a pedestrian request and vehicle demand exist together, WALK SHALL be served before the next green.
REQ-027 While i_hold=1, GREEN SHALL not exit; i_hold SHALL not affect YELLOW, ALLRED or WALK.
REQ-028 All outputs SHALL be registered and updated on the same edge as the phase change, with zero added latency.
REQ-029 Outputs per phase:
- GREEN: direction o_dir = 10, all others 00.
- YELLOW: direction o_dir = 01, all others 00.
- ALLRED: all directions 00.
- WALK: all directions 00, o_walk=1.
- o_walk SHALL be 0 in every phase other than WALK.

Reset
REQ-030 i_rst=1 SHALL, asynchronously, force phase GREEN, o_dir=0, timer=0 and ped_pend=0.
REQ-031 Under reset, outputs SHALL be o_light = direction 0 green with all others red (N_DIR=4: 8'h02), o_walk=0 and o_phase=0.
REQ-032 Reset asserted mid-phase SHALL abandon the phase immediately; operation resumes on the first edge after release.

Structure
REQ-033 The lamp codes (RED, YELLOW, GREEN) and phase encodings SHALL live in shared package traffic_pkg.
REQ-034 The phase timer SHALL be a sub-module phase_timer, with clear, enable and saturating count.
REQ-035 Elaboration SHALL fail if any T_* parameter is 0, if T_GREEN_MAX < T_GREEN_MIN, or if any T_* value exceeds 2^CNT_W-1.

Verification (N_DIR=4, defaults)
REQ-036 Release reset with i_sense=0 and i_ped=0 for 100 cycles -> o_light=8'h02 and o_phase=0 throughout.
REQ-037 Hold i_sense=4'b0100 from release -> dir0 green 4 cycles, yellow 2 cycles, all red 1 cycle, then o_dir=2 and o_light=8'h20.
REQ-038 Hold i_sense=4'b0011 -> dir0 stays green 10 cycles (max-out), then yellow, then o_dir=1.
REQ-039 One-cycle i_ped pulse at cycle 1 with i_sense=4'b0010 -> yellow, then all red, then o_walk=1 for exactly 3 cycles, then dir1 green; ped_pend=0 afterwards.
REQ-040 Put dir3 in GREEN, set i_sense=4'b1001 with i_hold=1 for 20 cycles -> no exit; release hold -> exit after own-sense drop or max, then wrap to o_dir=0.
REQ-041 Assert i_rst in the 2nd YELLOW cycle -> o_light=8'h02 and o_phase=0 before the next clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp codes and phase encodings for the round-robin traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PhGreen  = 2'd0,
        PhYellow = 2'd1,
        PhAllred = 2'd2,
        PhWalk   = 2'd3
    } phase_e;

    localparam logic [1:0] LampRed    = 2'b00;
    localparam logic [1:0] LampYellow = 2'b01;
    localparam logic [1:0] LampGreen  = 2'b10;

endpackage

// File: rtl/phase_timer.sv
// Phase timer: synchronous clear, count enable, saturates at all-ones instead of wrapping.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_rr.sv
// Round-robin traffic light controller with pedestrian walk phase and maintenance hold.
module traffic_light_rr
    import traffic_pkg::*;
#(
    parameter int unsigned N_DIR       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_GREEN_MIN = 4,
    parameter int unsigned T_GREEN_MAX = 10,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_WALK      = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_DIR-1:0]         i_sense,
    input  logic                     i_ped,
    input  logic                     i_hold,
    output logic [2*N_DIR-1:0]       o_light,
    output logic                     o_walk,
    output logic [$clog2(N_DIR)-1:0] o_dir,
    output logic [1:0]               o_phase
);

    localparam int unsigned      DirW     = $clog2(N_DIR);
    localparam longint unsigned  TimerMax = (64'd1 << CNT_W) - 64'd1;
    localparam logic [2*N_DIR-1:0] LightRst = {{(2*N_DIR-2){1'b0}}, LampGreen};

    if (N_DIR < 2 || N_DIR > 8) begin : g_bad_ndir
        $error("N_DIR must be within 2..8");
    end
    if (T_GREEN_MIN == 0 || T_GREEN_MAX == 0 || T_YELLOW == 0 || T_ALLRED == 0
        || T_WALK == 0) begin : g_bad_zero
        $error("phase lengths must be non-zero");
    end
    if (T_GREEN_MAX < T_GREEN_MIN) begin : g_bad_order
        $error("T_GREEN_MAX must not be below T_GREEN_MIN");
    end
    if (64'(T_GREEN_MIN) > TimerMax || 64'(T_GREEN_MAX) > TimerMax
        || 64'(T_YELLOW) > TimerMax || 64'(T_ALLRED) > TimerMax
        || 64'(T_WALK) > TimerMax) begin : g_bad_width
        $error("phase length does not fit in CNT_W-bit timer");
    end

    phase_e              phase_q, phase_d;
    logic [DirW-1:0]     dir_q, dir_d;
    logic                ped_q, ped_d;
    logic [2*N_DIR-1:0]  light_q, light_d;
    logic                walk_q, walk_d;
    logic [CNT_W-1:0]    timer;
    logic                timer_clr;
    logic [DirW-1:0]     nxt_dir;
    logic [DirW-1:0]     cand;
    logic                found;
    logic [N_DIR-1:0]    own_mask;
    logic                demand;
    logic                green_exit;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clr_i   (timer_clr),
        .en_i    (1'b1),
        .count_o (timer)
    );

    // Round-robin search for the next sensed direction; the current one is the last candidate.
    always_comb begin
        nxt_dir = (dir_q == DirW'(N_DIR - 1)) ? '0 : dir_q + 1'b1;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_DIR; k++) begin
            cand = DirW'((32'(dir_q) + k) % N_DIR);
            if (!found && i_sense[cand]) begin
                nxt_dir = cand;
                found   = 1'b1;
            end
        end
    end

    // Green exit decision. A timer already past the max (e.g. after a hold) exits at once.
    always_comb begin
        own_mask   = N_DIR'(1) << dir_q;
        demand     = (|(i_sense & ~own_mask)) || ped_q;
        green_exit = demand && !i_hold
                     && (timer >= CNT_W'(T_GREEN_MIN - 1))
                     && (!i_sense[dir_q] || (timer >= CNT_W'(T_GREEN_MAX - 1)));
    end

    // Phase sequencing, direction advance and pedestrian latch.
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        case (phase_q)
            PhGreen: begin
                if (green_exit) phase_d = PhYellow;
            end
            PhYellow: begin
                if (timer == CNT_W'(T_YELLOW - 1)) phase_d = PhAllred;
            end
            PhAllred: begin
                if (timer == CNT_W'(T_ALLRED - 1)) begin
                    if (ped_q) begin
                        phase_d = PhWalk;
                    end else begin
                        phase_d = PhGreen;
                        dir_d   = nxt_dir;
                    end
                end
            end
            PhWalk: begin
                if (timer == CNT_W'(T_WALK - 1)) begin
                    phase_d = PhGreen;
                    dir_d   = nxt_dir;
                end
            end
            default: phase_d = PhGreen;
        endcase
        // Entering WALK consumes the request even if i_ped is high on the same edge.
        ped_d     = (phase_d == PhWalk && phase_q != PhWalk) ? 1'b0 : (ped_q | i_ped);
        timer_clr = (phase_d != phase_q);
    end

    // Lamp outputs decoded from the next state so they register on the phase-change edge.
    always_comb begin
        light_d = '0;
        for (int unsigned k = 0; k < N_DIR; k++) begin
            if (DirW'(k) == dir_d) begin
                if (phase_d == PhGreen) begin
                    light_d[2*k +: 2] = LampGreen;
                end else if (phase_d == PhYellow) begin
                    light_d[2*k +: 2] = LampYellow;
                end
            end
        end
        walk_d = (phase_d == PhWalk);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= PhGreen;
            dir_q   <= '0;
            ped_q   <= 1'b0;
            light_q <= LightRst;
            walk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            ped_q   <= ped_d;
            light_q <= light_d;
            walk_q  <= walk_d;
        end
    end

    assign o_light = light_q;
    assign o_walk  = walk_q;
    assign o_dir   = dir_q;
    assign o_phase = phase_q;

endmodule

// File: tb/tb_traffic_light_rr.sv
// Randomized and directed bench for traffic_light_rr against a cycle-level behavioural model.
module tb_traffic_light_rr;

    localparam int N    = 4;
    localparam int TGMN = 4;
    localparam int TGMX = 10;
    localparam int TY   = 2;
    localparam int TA   = 1;
    localparam int TW   = 3;

    logic       clk;
    logic       rst;
    logic [3:0] sense;
    logic       ped;
    logic       hold;
    logic [7:0] o_light;
    logic       o_walk;
    logic [1:0] o_dir;
    logic [1:0] o_phase;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: phase 0..3, served direction, cycles spent in phase, pending ped request.
    int m_phase;
    int m_dir;
    int m_t;
    bit m_ped;

    traffic_light_rr dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sense (sense),
        .i_ped   (ped),
        .i_hold  (hold),
        .o_light (o_light),
        .o_walk  (o_walk),
        .o_dir   (o_dir),
        .o_phase (o_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int next_dir(input int d, input logic [3:0] s);
        for (int k = 1; k <= N; k++) begin
            if (s[(d + k) % N]) return (d + k) % N;
        end
        return (d + 1) % N;
    endfunction

    function automatic logic [7:0] exp_light();
        logic [7:0] l;
        l = 8'h00;
        if (m_phase == 0) l[2*m_dir +: 2] = 2'b10;
        else if (m_phase == 1) l[2*m_dir +: 2] = 2'b01;
        return l;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_dir   = 0;
        m_t     = 0;
        m_ped   = 0;
    endtask

    task automatic model_step();
        int  np;
        int  nd;
        bit  others;
        np     = m_phase;
        nd     = m_dir;
        others = 0;
        for (int k = 0; k < N; k++) begin
            if (k != m_dir && sense[k]) others = 1;
        end
        case (m_phase)
            0: if ((others || m_ped) && !hold && m_t >= TGMN - 1
                   && (!sense[m_dir] || m_t >= TGMX - 1)) np = 1;
            1: if (m_t == TY - 1) np = 2;
            2: if (m_t == TA - 1) begin
                   if (m_ped) np = 3;
                   else begin
                       np = 0;
                       nd = next_dir(m_dir, sense);
                   end
               end
            default: if (m_t == TW - 1) begin
                   np = 0;
                   nd = next_dir(m_dir, sense);
               end
        endcase
        if (np == 3 && m_phase != 3) m_ped = 0;
        else m_ped = m_ped | ped;
        m_t     = (np != m_phase) ? 0 : m_t + 1;
        m_phase = np;
        m_dir   = nd;
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "light"}, 32'(o_light), 32'(exp_light()));
        check({pfx, "walk"},  32'(o_walk),  32'(m_phase == 3));
        check({pfx, "dir"},   32'(o_dir),   32'(m_dir));
        check({pfx, "phase"}, 32'(o_phase), 32'(m_phase));
    endtask

    // One clock: inputs already stable; model steps with the same sampled inputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all("");
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all("rst_");
        check("rst_light_const", 32'(o_light), 32'h02);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int walk_cnt;

    initial begin
        rst   = 1'b1;
        sense = 4'b0000;
        ped   = 1'b0;
        hold  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Idle: dir0 rests green.
        do_reset();
        repeat (100) tick();
        check("idle_light", 32'(o_light), 32'h02);

        // Single other demand: 4 green, 2 yellow, 1 all-red, then dir2.
        do_reset();
        sense = 4'b0100;
        repeat (3) tick();
        check("d2_green3", 32'(o_phase), 32'd0);
        tick();
        check("d2_yellow", 32'(o_phase), 32'd1);
        repeat (3) tick();
        check("d2_dir", 32'(o_dir), 32'd2);
        check("d2_light", 32'(o_light), 32'h20);

        // Own demand kept: max-out after 10 cycles.
        do_reset();
        sense = 4'b0011;
        repeat (9) tick();
        check("max_green9", 32'(o_phase), 32'd0);
        tick();
        check("max_yellow", 32'(o_phase), 32'd1);
        repeat (3) tick();
        check("max_dir", 32'(o_dir), 32'd1);

        // Pedestrian pulse: walk lasts exactly 3 cycles, then dir1, and no further exits.
        do_reset();
        sense = 4'b0010;
        tick();
        ped = 1'b1;
        tick();
        ped = 1'b0;
        walk_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (o_walk) walk_cnt++;
        end
        check("ped_walk_cnt", 32'(walk_cnt), 32'd3);
        check("ped_dir", 32'(o_dir), 32'd1);
        repeat (10) tick();
        check("ped_rest", 32'(o_phase), 32'd0);

        // Hold on dir3 green, then release and wrap to dir0.
        do_reset();
        sense = 4'b1000;
        repeat (7) tick();
        check("hold_dir3", 32'(o_dir), 32'd3);
        sense = 4'b1001;
        hold  = 1'b1;
        repeat (20) tick();
        check("hold_frozen", 32'(o_phase), 32'd0);
        hold  = 1'b0;
        sense = 4'b0001;
        tick();
        check("hold_exit", 32'(o_phase), 32'd1);
        repeat (3) tick();
        check("hold_wrap", 32'(o_dir), 32'd0);

        // Asynchronous reset in the second yellow cycle.
        do_reset();
        sense = 4'b0100;
        repeat (5) tick();
        check("ar_yellow2", 32'(o_phase), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_light", 32'(o_light), 32'h02);
        check("ar_phase", 32'(o_phase), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) sense = 4'($urandom_range(15));
            ped = ($urandom_range(11) == 0);
            if ($urandom_range(19) == 0) hold = ~hold;
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
